// File: rtl/req_encoder.sv
// req_encoder: captures request pulses into a pending set and presents the
// lowest-numbered pending index, one at a time, under a valid/ack handshake.
module req_encoder #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [2**N-1:0]   req,
    input  logic              clr,
    input  logic              ack,
    output logic [N-1:0]      out_idx,
    output logic              out_valid,
    output logic              overflow
);
    localparam int W = 2**N;
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t         state;
    logic [W-1:0]   pending;
    logic [W-1:0]   clear_mask;
    logic [W-1:0]   set_mask;
    logic [W-1:0]   kept;
    logic [N-1:0]   win;
    logic           merge;
    always_comb begin
        win = '0;
        for (int i = W - 1; i >= 0; i--)
            if (pending[i]) win = N'(i);
    end
    // The acked bit is cleared before new requests are ORed in, so a
    // same-edge re-request survives and is not counted as a merge.
    always_comb begin
        clear_mask = (state == PRESENT && ack) ? ({{(W-1){1'b0}}, 1'b1} << out_idx) : '0;
        set_mask   = enable ? req : '0;
        kept       = pending & ~clear_mask;
        merge      = |(set_mask & kept);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            pending <= kept | set_mask;
            if (merge) overflow <= 1'b1;
            if (state == IDLE) begin
                if (enable && |pending) begin
                    state     <= PRESENT;
                    out_idx   <= win;
                    out_valid <= 1'b1;
                end
            end else if (ack) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_req_encoder.sv
// tb_req_encoder: directed scenarios plus random traffic against a
// set-of-pending-events reference model.
module tb_req_encoder;
    localparam int N = 3;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset_n, enable, clr, ack;
    logic [W-1:0] req;
    logic [N-1:0] out_idx;
    logic out_valid, overflow;
    int checks = 0;
    int failures = 0;
    bit m_ev [W];
    bit m_valid, m_ovf;
    int m_idx;

    req_encoder #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .req(req), .clr(clr),
        .ack(ack), .out_idx(out_idx), .out_valid(out_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit any_pending();
        foreach (m_ev[i]) if (m_ev[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lowest_pending();
        for (int i = 0; i < W; i++) if (m_ev[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        foreach (m_ev[i]) m_ev[i] = 1'b0;
        m_valid = 1'b0;
        m_ovf = 1'b0;
        m_idx = 0;
    endtask

    task automatic model_edge();
        bit nxt [W];
        bit launch, done;
        int acked;
        if (clr) begin
            foreach (m_ev[i]) m_ev[i] = 1'b0;
            m_valid = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        acked = (m_valid && ack) ? m_idx : -1;
        launch = !m_valid && enable && any_pending();
        done = m_valid && ack;
        foreach (m_ev[i]) begin
            nxt[i] = m_ev[i] && (i != acked);
            if (enable && req[i]) begin
                if (nxt[i]) m_ovf = 1'b1;
                nxt[i] = 1'b1;
            end
        end
        if (launch) begin
            m_idx = lowest_pending();
            m_valid = 1'b1;
        end else if (done) m_valid = 1'b0;
        m_ev = nxt;
    endtask

    task automatic check_all(input string tag);
        cmp({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        cmp({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        cmp({tag, "_idx"}, 32'(out_idx), 32'(m_idx));
    endtask

    task automatic step(input bit en, input logic [W-1:0] r, input bit c, input bit a, input string tag);
        enable = en;
        req = r;
        clr = c;
        ack = a;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        req = '0;
        clr = 1'b0;
        ack = 1'b0;
        model_reset();
        #2;
        cmp("rst_valid", 32'(out_valid), 0);
        cmp("rst_idx", 32'(out_idx), 0);
        cmp("rst_ovf", 32'(overflow), 0);
        #10 reset_n = 1'b1;

        // two-edge latency, priority order, one idle cycle between presentations
        step(1, 8'h24, 0, 0, "r27a");
        cmp("r27_lat1", 32'(out_valid), 0);
        step(1, 8'h00, 0, 0, "r27b");
        cmp("r27_idx2", 32'(out_idx), 2);
        cmp("r27_v2", 32'(out_valid), 1);
        step(1, 8'h00, 0, 1, "r27c");
        cmp("r27_gap", 32'(out_valid), 0);
        step(1, 8'h00, 0, 0, "r27d");
        cmp("r27_idx5", 32'(out_idx), 5);
        step(1, 8'h00, 0, 1, "r27e");
        step(1, 8'h00, 0, 0, "r27f");
        cmp("r27_empty", 32'(out_valid), 0);

        // presented index is held while a higher-priority request arrives
        step(1, 8'h20, 0, 0, "r28a");
        step(1, 8'h00, 0, 0, "r28b");
        step(1, 8'h01, 0, 0, "r28c");
        cmp("r28_hold", 32'(out_idx), 5);
        step(0, 8'h00, 0, 0, "r28d");
        step(1, 8'h00, 0, 1, "r28e");
        step(1, 8'h00, 0, 0, "r28f");
        cmp("r28_next0", 32'(out_idx), 0);
        step(1, 8'h00, 0, 1, "r28g");

        // overflow, set-wins on ack edge, clr flush
        step(1, 8'h08, 0, 0, "r29a");
        step(1, 8'h00, 0, 0, "r29b");
        step(1, 8'h08, 0, 0, "r29c");
        cmp("r29_ovf", 32'(overflow), 1);
        step(1, 8'h08, 0, 1, "r29d");
        cmp("r29_ovf_keep", 32'(overflow), 1);
        step(1, 8'h00, 0, 0, "r29e");
        cmp("r29_repres", 32'(out_idx), 3);
        cmp("r29_repres_v", 32'(out_valid), 1);
        step(1, 8'h00, 1, 0, "r29f");
        cmp("r29_clr_ovf", 32'(overflow), 0);
        step(1, 8'h00, 0, 0, "r29g");
        cmp("r29_clr_pend", 32'(out_valid), 0);

        // ack while idle ignored; enable low blocks capture and launch
        step(1, 8'h00, 0, 1, "ackidle");
        step(0, 8'hFF, 0, 0, "r30a");
        step(1, 8'h00, 0, 0, "r30b");
        cmp("r30_nocap", 32'(out_valid), 0);
        step(1, 8'h10, 0, 0, "r30c");
        step(0, 8'h00, 0, 0, "r30d");
        step(0, 8'h00, 0, 0, "r30e");
        cmp("r30_nolaunch", 32'(out_valid), 0);
        step(1, 8'h00, 0, 0, "r30f");
        cmp("r30_idx4", 32'(out_idx), 4);
        step(1, 8'h00, 0, 1, "r30g");

        // clr and ack on the same edge
        step(1, 8'h42, 0, 0, "r32a");
        step(1, 8'h00, 0, 0, "r32b");
        step(1, 8'h00, 1, 1, "r32c");
        step(1, 8'h00, 0, 0, "r32d");
        step(1, 8'h00, 0, 0, "r32e");
        cmp("r32_idle", 32'(out_valid), 0);

        // asynchronous reset mid-cycle while presenting with overflow set
        step(1, 8'h80, 0, 0, "r31a");
        step(1, 8'h00, 0, 0, "r31b");
        step(1, 8'h80, 0, 0, "r31c");
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        cmp("r31_async_v", 32'(out_valid), 0);
        cmp("r31_async_idx", 32'(out_idx), 0);
        cmp("r31_async_ovf", 32'(overflow), 0);
        enable = 1'b1;
        req = 8'hFF;
        @(posedge clk);
        #1;
        check_all("r31_held");
        req = '0;
        #2 reset_n = 1'b1;
        step(1, 8'h00, 0, 0, "r31d");
        step(1, 8'h00, 0, 0, "r31e");
        cmp("r31_norelaunch", 32'(out_valid), 0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            logic [W-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? W'($urandom) & W'($urandom) : '0;
            step($urandom_range(0, 7) != 0, r, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) == 0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
